ch1_sweep_freq: RTL and testbench
=================================

# ch1_sweep_freq

Frequency register and sweep arithmetic unit for APU channel 1. Holds the 11-bit channel-1 frequency written through FF13/FF14, keeps a shadow shift register, and computes sweep updates (freq ± shadow) when strobed by the channel-1 sweep sequencer. Returns the no-overflow flag `atys`, which the sequencer uses to stop the channel and gate further sweep updates. Supplies the frequency to the channel-1 period counter.

## Interface
Parameters:
- `FREQ_W`, 11, frequency/shadow width.

Ports:
- `ajer_2mhz` in 1: the only clock; all inputs are sampled on its rising edge.
- `apu_reset` in 1: synchronous, active-high reset.
- `apu_wr` in 1: CPU write strobe, one cycle.
- `ff13` in 1: FF13 (freq low) selected.
- `ff14` in 1: FF14 (freq high) selected.
- `d` in 8: CPU write data.
- `nff10_d3` in 1: inverted FF10 bit 3; low = subtract.
- `ch1_restart` in 1: trigger pulse.
- `ch1_ld_shift` in 1: load shadow from freq.
- `ch1_shift_clk` in 1: shift shadow right by one.
- `ch1_freq_upd1` in 1: compute sum and check overflow.
- `ch1_freq_upd2` in 1: commit the computed sum.
- `ch1_freq` out FREQ_W: current frequency.
- `ch1_freq_ld` out 1: one-cycle pulse whenever `ch1_freq` changes by commit.
- `atys` out 1: high = no overflow; sticky low after overflow.

## Operation
- All state is registered. Reset: `ch1_freq`=0, shadow=0, result=0, result_valid=0, `atys`=1, `ch1_freq_ld`=0.
- CPU write: `apu_wr&ff13` → freq[7:0]<=d. `apu_wr&ff14` → freq[10:8]<=d[2:0]. Other bits of d are ignored.
- Shadow: `ch1_restart` or `ch1_ld_shift` → shadow<=freq. Else `ch1_shift_clk` → shadow<=shadow>>1, zero fill. Load wins over shift.
- Sum (12-bit): add when `nff10_d3`=1: {0,freq}+{0,shadow}; subtract: {0,freq}−{0,shadow}.
- `ch1_freq_upd1`: result<=sum[10:0]. Add with sum[11]=1 → `atys`<=0 and result_valid<=0. Otherwise result_valid<=1. In subtract, a borrow (shadow>freq) sets result_valid<=0 and leaves `atys` unchanged.
- `ch1_freq_upd2`: if result_valid & `atys` → freq<=result, `ch1_freq_ld` pulses, result_valid<=0. Otherwise no effect.
- `ch1_restart`: `atys`<=1, result_valid<=0, shadow<=freq.
- Simultaneous events, by priority:
  - `apu_reset` overrides everything.
  - A CPU write in the same cycle as upd2 suppresses the commit. The written byte is applied over the old freq, and result_valid is cleared.
  - restart with upd1 or upd2: restart wins; both strobes are ignored.
  - upd1 and upd2 in the same cycle: upd2 uses the previous result; upd1 then registers the new one.

## Timing
- A strobe at edge N gives updated outputs after edge N, visible in cycle N+1. Latency is 1 cycle.
- upd1 → upd2 minimum spacing is 1 cycle; there is no maximum.
- `atys` falls 1 cycle after the overflowing upd1. It stays low until restart or reset.
- `ch1_freq_ld` is high for exactly the cycle after the commit edge.
- A strobe arriving during reset is lost; nothing is queued.

## Configuration
- `CH1_SWEEP_EN` defined: full behaviour as above.
- `CH1_SWEEP_EN` undefined:
  - shadow, adder and result are not compiled; `ch1_freq_upd1`, `ch1_freq_upd2`, `ch1_ld_shift` and `ch1_shift_clk` are ignored.
  - `atys` is a constant 1; `ch1_freq_ld` is a constant 0.
  - The block reduces to the CPU-written frequency register.

## Structure
- Package `apu_pkg` holds:
  - `FREQ_W`=11 as a localparam default;
  - `typedef logic [10:0] ch_freq_t`;
  - `typedef enum {SW_ADD, SW_SUB} sweep_dir_t`.
- Sub-module `ch1_sweep_shifter` contains the shadow register, with load/shift priority and zero fill. The adder, overflow logic and commit logic stay in the top module.

## Test plan
1. Reset is held 2 cycles → `ch1_freq`=0x000, `atys`=1, `ch1_freq_ld`=0.
2. Overflow:
   - stimulus: FF13=0x00, FF14=0x07 (freq=0x700), ld_shift, 1 shift_clk (shadow=0x380), add, upd1, upd2;
   - required: sum=0xA80, `atys`=0 one cycle after upd1, freq stays 0x700, no `ch1_freq_ld`.
3. Subtract: freq=0x100, ld_shift, 2 shift_clk (shadow=0x040), `nff10_d3`=0, upd1, upd2 → freq=0x0C0, `ch1_freq_ld` pulses once.
4. Add commit: freq=0x400, 1 shift_clk (0x200), upd1, upd2 → freq=0x600. A second upd2 without upd1 leaves freq unchanged.
5. Collision: freq=0x400, result pending 0x600, FF13 write d=0x55 in the same cycle as upd2 → freq=0x455, no `ch1_freq_ld`.
6. Recovery: after test 2, `ch1_restart` → `atys`=1 next cycle, shadow=0x700. Also check that with `CH1_SWEEP_EN` undefined, the upd strobes never change freq and `atys` stays 1.

Source files
------------

// File: rtl/ch1_sweep_freq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apu_pkg                                                              |
// | Shared types and defaults for the channel-1 sweep/frequency block.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package apu_pkg;
  localparam int FREQ_W = 11;

  typedef logic [10:0] ch_freq_t;

  typedef enum logic {SW_ADD, SW_SUB} sweep_dir_t;

  // FF10 bit 3 arrives inverted, so a high level selects addition
  function automatic sweep_dir_t sweep_dir(input logic nff10_d3);
    return nff10_d3 ? SW_ADD : SW_SUB;
  endfunction
endpackage
`default_nettype wire

// File: rtl/ch1_sweep_freq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ch1_sweep_freq_if                                                    |
// | CPU write bus, sweep sequencer strobes and frequency outputs.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ch1_sweep_freq_if #(
  parameter int FREQ_W = apu_pkg::FREQ_W
);
  logic              apu_wr;
  logic              ff13;
  logic              ff14;
  logic [7:0]        d;
  logic              nff10_d3;
  logic              ch1_restart;
  logic              ch1_ld_shift;
  logic              ch1_shift_clk;
  logic              ch1_freq_upd1;
  logic              ch1_freq_upd2;
  logic [FREQ_W-1:0] ch1_freq;
  logic              ch1_freq_ld;
  logic              atys;

  modport master (
    output apu_wr, ff13, ff14, d, nff10_d3, ch1_restart, ch1_ld_shift,
           ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2,
    input  ch1_freq, ch1_freq_ld, atys
  );

  modport slave (
    input  apu_wr, ff13, ff14, d, nff10_d3, ch1_restart, ch1_ld_shift,
           ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2,
    output ch1_freq, ch1_freq_ld, atys
  );
endinterface
`default_nettype wire

// File: rtl/ch1_sweep_freq_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ch1_sweep_shifter                                                    |
// | Sweep shadow register: parallel load from freq, or right shift.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ch1_sweep_shifter #(
  parameter int FREQ_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [FREQ_W-1:0] freq_i,
  output logic [FREQ_W-1:0] shadow_o
);
  import apu_pkg::*;

  logic [FREQ_W-1:0] shadow_q;
  logic [FREQ_W-1:0] shadow_d;

  // Load takes precedence so a restart never sees a half-shifted value
  always_comb begin
    shadow_d = shadow_q;
    if (load_i) begin
      shadow_d = freq_i;
    end else if (shift_i) begin
      shadow_d = shadow_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;
endmodule
`default_nettype wire

// File: rtl/ch1_sweep_freq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ch1_sweep_freq                                                       |
// | Channel-1 frequency register with sweep add/subtract and overflow.   |
// | Sweep datapath present only when CH1_SWEEP_EN is defined.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ch1_sweep_freq #(
  parameter int FREQ_W = apu_pkg::FREQ_W
) (
  input  logic            ajer_2mhz,
  input  logic            apu_reset,
  ch1_sweep_freq_if.slave bus
);
  import apu_pkg::*;

  logic              wr13;
  logic              wr14;
  logic              cpu_wr;
  logic [FREQ_W-1:0] freq_q;
  logic [FREQ_W-1:0] freq_d;
  logic [FREQ_W-1:0] freq_cpu;

  assign wr13   = bus.apu_wr & bus.ff13;
  assign wr14   = bus.apu_wr & bus.ff14;
  assign cpu_wr = wr13 | wr14;

  always_comb begin
    freq_cpu = freq_q;
    if (wr13) freq_cpu[7:0]  = bus.d;
    if (wr14) freq_cpu[10:8] = bus.d[2:0];
  end

  always_ff @(posedge ajer_2mhz) begin
    if (apu_reset) begin
      freq_q <= '0;
    end else begin
      freq_q <= freq_d;
    end
  end

  assign bus.ch1_freq = freq_q;

`ifdef CH1_SWEEP_EN
  logic [FREQ_W-1:0] shadow;
  logic [FREQ_W:0]   sum;
  sweep_dir_t        dir;
  logic              overflow;
  logic              borrow;
  logic              commit;
  logic [FREQ_W-1:0] result_q;
  logic [FREQ_W-1:0] result_d;
  logic              result_valid_q;
  logic              result_valid_d;
  logic              atys_q;
  logic              atys_d;
  logic              freq_ld_q;
  logic              freq_ld_d;

  ch1_sweep_shifter #(
    .FREQ_W (FREQ_W)
  ) u_shifter (
    .clk      (ajer_2mhz),
    .rst      (apu_reset),
    .load_i   (bus.ch1_restart | bus.ch1_ld_shift),
    .shift_i  (bus.ch1_shift_clk),
    .freq_i   (freq_q),
    .shadow_o (shadow)
  );

  assign dir = sweep_dir(bus.nff10_d3);
  assign sum = (dir == SW_ADD) ? ({1'b0, freq_q} + {1'b0, shadow})
                               : ({1'b0, freq_q} - {1'b0, shadow});
  // The carry-out bit doubles as the borrow flag when subtracting
  assign overflow = (dir == SW_ADD) & sum[FREQ_W];
  assign borrow   = (dir == SW_SUB) & sum[FREQ_W];

  // A same-cycle CPU write or restart must not be overwritten by a commit
  assign commit = bus.ch1_freq_upd2 & result_valid_q & atys_q & ~cpu_wr & ~bus.ch1_restart;

  always_comb begin
    freq_d         = commit ? result_q : freq_cpu;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    atys_d         = atys_q;
    freq_ld_d      = commit;
    if (bus.ch1_restart) begin
      atys_d         = 1'b1;
      result_valid_d = 1'b0;
    end else begin
      if (bus.ch1_freq_upd2 & (cpu_wr | commit)) result_valid_d = 1'b0;
      if (bus.ch1_freq_upd1) begin
        result_d       = sum[FREQ_W-1:0];
        result_valid_d = ~(overflow | borrow);
        if (overflow) atys_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ajer_2mhz) begin
    if (apu_reset) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      atys_q         <= 1'b1;
      freq_ld_q      <= 1'b0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      atys_q         <= atys_d;
      freq_ld_q      <= freq_ld_d;
    end
  end

  assign bus.atys        = atys_q;
  assign bus.ch1_freq_ld = freq_ld_q;
`else
  logic unused_sweep;

  assign freq_d          = freq_cpu;
  assign bus.atys        = 1'b1;
  assign bus.ch1_freq_ld = 1'b0;
  assign unused_sweep    = ^{bus.nff10_d3, bus.ch1_restart, bus.ch1_ld_shift,
                             bus.ch1_shift_clk, bus.ch1_freq_upd1, bus.ch1_freq_upd2};
`endif
endmodule
`default_nettype wire

// File: tb/tb_ch1_sweep_freq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ch1_sweep_freq                                                    |
// | Directed vector table plus randomized run against a reference model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ch1_sweep_freq;
  localparam int F_RST = 1;
  localparam int F_W13 = 2;
  localparam int F_W14 = 4;
  localparam int F_ADD = 8;
  localparam int F_RS  = 16;
  localparam int F_LDS = 32;
  localparam int F_SH  = 64;
  localparam int F_U1  = 128;
  localparam int F_U2  = 256;

  typedef struct {
    int        fl;
    logic [7:0] d;
    int        ef;   // expected freq, sweep enabled
    bit        el;   // expected freq_ld, sweep enabled
    bit        ea;   // expected atys, sweep enabled
    int        df;   // expected freq, sweep disabled
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ch1_sweep_freq_if #(.FREQ_W(11)) bus ();

  ch1_sweep_freq #(.FREQ_W(11)) dut (
    .ajer_2mhz (clk),
    .apu_reset (rst),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state: plain integers, updated once per clock
  int m_freq, m_shadow, m_result;
  bit m_valid, m_atys, m_ld;

  task automatic model_step(input int fl, input logic [7:0] d);
    int  sum;
    int  nf;
    bit  cpuw;
    if ((fl & F_RST) != 0) begin
      m_freq = 0; m_shadow = 0; m_result = 0;
      m_valid = 0; m_atys = 1; m_ld = 0;
      return;
    end
    cpuw = (fl & (F_W13 | F_W14)) != 0;
    nf   = m_freq;
    if ((fl & F_W13) != 0) nf = (nf & 'h700) | int'(d);
    if ((fl & F_W14) != 0) nf = (nf & 'h0FF) | ((int'(d) & 7) << 8);
`ifdef CH1_SWEEP_EN
    m_ld = 0;
    sum  = ((fl & F_ADD) != 0) ? m_freq + m_shadow : m_freq - m_shadow;
    if ((fl & F_RS) != 0) begin
      m_atys  = 1;
      m_valid = 0;
    end else begin
      if ((fl & F_U2) != 0) begin
        if (cpuw) m_valid = 0;
        else if (m_valid && m_atys) begin
          nf = m_result; m_ld = 1; m_valid = 0;
        end
      end
      if ((fl & F_U1) != 0) begin
        m_result = sum & 'h7FF;
        if ((fl & F_ADD) != 0 && sum > 'h7FF) begin
          m_atys = 0; m_valid = 0;
        end else begin
          m_valid = (sum >= 0);
        end
      end
    end
    if ((fl & (F_RS | F_LDS)) != 0) m_shadow = m_freq;
    else if ((fl & F_SH) != 0)      m_shadow = m_shadow / 2;
`else
    cpuw = cpuw;
    sum  = 0;
`endif
    m_freq = nf;
  endtask

  task automatic drive(input int fl, input logic [7:0] d);
    rst               = (fl & F_RST) != 0;
    bus.apu_wr        = (fl & (F_W13 | F_W14)) != 0;
    bus.ff13          = (fl & F_W13) != 0;
    bus.ff14          = (fl & F_W14) != 0;
    bus.d             = d;
    bus.nff10_d3      = (fl & F_ADD) != 0;
    bus.ch1_restart   = (fl & F_RS) != 0;
    bus.ch1_ld_shift  = (fl & F_LDS) != 0;
    bus.ch1_shift_clk = (fl & F_SH) != 0;
    bus.ch1_freq_upd1 = (fl & F_U1) != 0;
    bus.ch1_freq_upd2 = (fl & F_U2) != 0;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    int         ef;
    bit         el;
    bit         ea;
    int         fl;
    logic [7:0] rd;
    checks   = 0;
    failures = 0;
    drive(F_RST, 8'h00);

    // reset held two cycles
    tbl.push_back('{F_RST,               8'h00, 'h000, 0, 1, 'h000});
    tbl.push_back('{F_RST,               8'h00, 'h000, 0, 1, 'h000});
    // overflow: 0x700 + 0x380
    tbl.push_back('{F_W13,               8'h00, 'h000, 0, 1, 'h000});
    tbl.push_back('{F_W14,               8'h07, 'h700, 0, 1, 'h700});
    tbl.push_back('{F_LDS,               8'h00, 'h700, 0, 1, 'h700});
    tbl.push_back('{F_SH,                8'h00, 'h700, 0, 1, 'h700});
    tbl.push_back('{F_ADD | F_U1,        8'h00, 'h700, 0, 0, 'h700});
    tbl.push_back('{F_ADD | F_U2,        8'h00, 'h700, 0, 0, 'h700});
    tbl.push_back('{0,                   8'h00, 'h700, 0, 0, 'h700});
    // recovery: shadow reloads 0x700, 0x700-0x700 commits 0
    tbl.push_back('{F_RS,                8'h00, 'h700, 0, 1, 'h700});
    tbl.push_back('{F_U1,                8'h00, 'h700, 0, 1, 'h700});
    tbl.push_back('{F_U2,                8'h00, 'h000, 1, 1, 'h700});
    tbl.push_back('{0,                   8'h00, 'h000, 0, 1, 'h700});
    // subtract: 0x100 - 0x040
    tbl.push_back('{F_W14,               8'h01, 'h100, 0, 1, 'h100});
    tbl.push_back('{F_LDS,               8'h00, 'h100, 0, 1, 'h100});
    tbl.push_back('{F_SH,                8'h00, 'h100, 0, 1, 'h100});
    tbl.push_back('{F_SH,                8'h00, 'h100, 0, 1, 'h100});
    tbl.push_back('{F_U1,                8'h00, 'h100, 0, 1, 'h100});
    tbl.push_back('{F_U2,                8'h00, 'h0C0, 1, 1, 'h100});
    tbl.push_back('{0,                   8'h00, 'h0C0, 0, 1, 'h100});
    // add commit: 0x400 + 0x200, second upd2 is inert
    tbl.push_back('{F_W13,               8'h00, 'h000, 0, 1, 'h100});
    tbl.push_back('{F_W14,               8'h04, 'h400, 0, 1, 'h400});
    tbl.push_back('{F_LDS,               8'h00, 'h400, 0, 1, 'h400});
    tbl.push_back('{F_SH,                8'h00, 'h400, 0, 1, 'h400});
    tbl.push_back('{F_ADD | F_U1,        8'h00, 'h400, 0, 1, 'h400});
    tbl.push_back('{F_ADD | F_U2,        8'h00, 'h600, 1, 1, 'h400});
    tbl.push_back('{F_ADD | F_U2,        8'h00, 'h600, 0, 1, 'h400});
    // collision: CPU write during upd2 wins, pending result dropped
    tbl.push_back('{F_W13,               8'h00, 'h600, 0, 1, 'h400});
    tbl.push_back('{F_W14,               8'h04, 'h400, 0, 1, 'h400});
    tbl.push_back('{F_ADD | F_U1,        8'h00, 'h400, 0, 1, 'h400});
    tbl.push_back('{F_W13 | F_ADD | F_U2, 8'h55, 'h455, 0, 1, 'h455});
    tbl.push_back('{F_ADD | F_U2,        8'h00, 'h455, 0, 1, 'h455});
    // upd1+upd2 together, then restart masking upd2
    tbl.push_back('{F_ADD | F_U1,        8'h00, 'h455, 0, 1, 'h455});
    tbl.push_back('{F_ADD | F_U1 | F_U2, 8'h00, 'h655, 1, 1, 'h455});
    tbl.push_back('{F_RS | F_U2,         8'h00, 'h655, 0, 1, 'h455});
    tbl.push_back('{F_U2,                8'h00, 'h655, 0, 1, 'h455});
    // strobe during reset is lost
    tbl.push_back('{F_RST | F_ADD | F_U1, 8'h00, 'h000, 0, 1, 'h000});
    tbl.push_back('{F_U2,                8'h00, 'h000, 0, 1, 'h000});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fl, tbl[i].d);
      @(posedge clk);
      #1;
`ifdef CH1_SWEEP_EN
      ef = tbl[i].ef; el = tbl[i].el; ea = tbl[i].ea;
`else
      ef = tbl[i].df; el = 1'b0; ea = 1'b1;
`endif
      check("dir_freq", i, 32'(bus.ch1_freq), 32'(ef));
      check("dir_ld",   i, 32'(bus.ch1_freq_ld), 32'(el));
      check("dir_atys", i, 32'(bus.atys), 32'(ea));
    end

    for (int i = 0; i < 800; i++) begin
      fl = 0;
      if (i == 0 || $urandom_range(0, 63) == 0) fl |= F_RST;
      if ($urandom_range(0, 7) == 0)  fl |= F_W13;
      if ($urandom_range(0, 7) == 0)  fl |= F_W14;
      if ($urandom_range(0, 1) == 0)  fl |= F_ADD;
      if ($urandom_range(0, 15) == 0) fl |= F_RS;
      if ($urandom_range(0, 11) == 0) fl |= F_LDS;
      if ($urandom_range(0, 3) == 0)  fl |= F_SH;
      if ($urandom_range(0, 3) == 0)  fl |= F_U1;
      if ($urandom_range(0, 2) == 0)  fl |= F_U2;
      rd = 8'($urandom);
      drive(fl, rd);
      model_step(fl, rd);
      @(posedge clk);
      #1;
      check("rnd_freq", i, 32'(bus.ch1_freq), 32'(m_freq));
      check("rnd_ld",   i, 32'(bus.ch1_freq_ld), 32'(m_ld));
      check("rnd_atys", i, 32'(bus.atys), 32'(m_atys));
    end

    drive(0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
